int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
Wishbone-slave interrupt controller sitting between the peripheral INT lines (keyboard, counter, disk, switch, ...) and the CPU's INT/Cause_in inputs.
- Edge-detects each source into a pending latch and applies a mask.
- Priority-encodes the highest-priority pending source into a CPU cause code, replacing the ad-hoc OR/ternary chain in the top level.
- Software reads, claims, clears and masks interrupts through four bus registers.

Parameters:
N_SRC, 6, number of interrupt sources (1..32); bit i maps to cause value i.
MASK_RESET, 32'hFFFF_FFFF, reset value of MASK (bits >= N_SRC ignored).
NO_IRQ_CAUSE, 32'hFFFF_FFFF, CAUSE value when nothing is pending and enabled.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
rst  in  1  synchronous active-high reset.
STB  in  1  bus strobe; held high until ACK is seen.
WE  in  1  bus write enable; valid while STB is high.
ADDR  in  32  byte address; only ADDR[3:2] is decoded.
DAT_I  in  32  write data.
DAT_O  out  32  read data.
ACK  out  1  bus acknowledge.
irq_src  in  N_SRC  raw peripheral interrupt levels.
INT  out  1  to CPU INT; high while any pending&mask bit is set.
CAUSE  out  32  to CPU Cause_in.

Behaviour:
- Reset (synchronous, active-high)
  - PENDING=0, MASK=MASK_RESET[N_SRC-1:0], irq_prev=0.
  - ACK=0, DAT_O=0, INT=0, CAUSE=NO_IRQ_CAUSE.
  - An in-flight bus cycle is dropped and no side effect occurs. The master must re-strobe.
- Edge detect
  - rise[i] = irq_src_s[i] & ~irq_prev[i], where irq_src_s is irq_src (or its synchronised copy, see Optional Feature).
  - irq_prev is updated every cycle.
  - rise[i] sets PENDING[i] on the next edge. Latching is independent of MASK.
- Interrupt outputs
  - active = PENDING & MASK.
  - INT and CAUSE are registered from the current active, so they lag a PENDING/MASK change by one cycle.
  - CAUSE = index of the lowest set bit of active, zero-extended to 32 bits; NO_IRQ_CAUSE when active==0.
- Register map (ADDR[3:2])
  - 0 PENDING: read returns PENDING. Write is write-1-to-clear.
  - 1 MASK: read/write.
  - 2 CAUSE: read-only; writes are ignored but still ACKed.
  - 3 CLAIM: read returns the current CAUSE and clears that PENDING bit (no clear when the value is NO_IRQ_CAUSE). Writes are ignored.
  - Bits >= N_SRC read as 0 and are ignored on write.
- Bus handshake, 2-state FSM
  - IDLE: when STB=1, perform the access (read/write side effects), load DAT_O, set ACK=1, go to WAIT.
  - WAIT: ACK stays 1 and DAT_O stays stable until STB=0. Then ACK=0 and go to IDLE.
  - Side effects happen exactly once per transaction, however long STB is held.
  - Latency: ACK rises on the first clk edge after STB is sampled high. A back-to-back STB needs at least one low cycle.
- Simultaneous events
  - A rise[i] in the same cycle as a PENDING clear (W1C or CLAIM) of bit i leaves PENDING[i]=1; set wins.
  - A MASK write and an edge in the same cycle: the edge is latched and the new mask is applied.
- A level held high does not re-trigger. The source must drop and rise again.

Optional Feature:
- Macro: INT_CTRL_SYNC_EN.
- Defined: irq_src passes through a 2-flop synchroniser per bit before edge detection. Edge-to-PENDING latency is 3 cycles and edge-to-INT latency is 4 cycles.
- Undefined: irq_src feeds edge detection directly. Edge-to-PENDING latency is 1 cycle and edge-to-INT latency is 2 cycles. Sources must already be synchronous to clk.

Decomposition:
- Package int_ctrl_pkg holds:
  - register offsets REG_PENDING=2'd0, REG_MASK=2'd1, REG_CAUSE=2'd2, REG_CLAIM=2'd3;
  - bus FSM state encoding BUS_IDLE/BUS_WAIT;
  - default NO_IRQ_CAUSE.
- One natural sub-module: int_prio_enc, a combinational lowest-index priority encoder over N_SRC bits producing {valid, index[4:0]}.

Test Plan:
- Reset with MASK_RESET default; pulse irq_src[3] 0->1 -> PENDING=32'h8. INT=1 and CAUSE=32'h3 arrive 2 cycles after the edge (4 cycles with INT_CTRL_SYNC_EN).
- Sources 5 and 1 rise together -> CAUSE=32'h1. Read CLAIM -> DAT_O=32'h1, PENDING=32'h20, then CAUSE=32'h5. Read CLAIM again -> DAT_O=32'h5, INT=0, CAUSE=32'hFFFF_FFFF.
- Write MASK=32'h0 with PENDING=32'h4 -> INT=0. PENDING read still returns 32'h4. Write MASK=32'h4 -> INT=1, CAUSE=32'h2.
- Hold STB high for 10 cycles on a CLAIM read -> ACK high from cycle 1 until STB drops, and only one PENDING bit is cleared.
- Write PENDING=32'h1 in the same cycle irq_src[0] rises -> PENDING[0] stays 1.
- Assert rst in WAIT with STB still high -> next cycle ACK=0, PENDING=0, CAUSE=32'hFFFF_FFFF. After STB drops and re-strobes, the FSM completes a normal transaction.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared constants for the int_ctrl interrupt controller: register offsets,
// bus FSM state encoding and the default "nothing pending" cause code.
package int_ctrl_pkg;

    localparam int unsigned BUS_W = 32;
    localparam int unsigned IDX_W = 5;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_CAUSE   = 2'd2;
    localparam logic [1:0] REG_CLAIM   = 2'd3;

    localparam logic [BUS_W-1:0] NO_IRQ_CAUSE_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_WAIT = 1'b1
    } bus_state_e;

endpackage

// File: rtl/int_ctrl_if.sv
// Wishbone-style slave bus between the CPU and int_ctrl: strobe, write
// enable, byte address, write/read data and acknowledge.
interface int_ctrl_if;

    logic                          STB;
    logic                          WE;
    logic [int_ctrl_pkg::BUS_W-1:0] ADDR;
    logic [int_ctrl_pkg::BUS_W-1:0] DAT_I;
    logic [int_ctrl_pkg::BUS_W-1:0] DAT_O;
    logic                          ACK;

    modport master (output STB, WE, ADDR, DAT_I, input DAT_O, ACK);
    modport slave  (input STB, WE, ADDR, DAT_I, output DAT_O, ACK);

endinterface

// File: rtl/int_prio_enc.sv
// Combinational lowest-index priority encoder: index of the lowest set bit
// of vec, with valid low when vec is all zero.
module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC = 6
) (
    input  logic [N_SRC-1:0] vec,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                valid = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detects peripheral IRQ lines into PENDING, masks
// and priority-encodes them into INT/CAUSE, and exposes PENDING/MASK/CAUSE/CLAIM
// over a Wishbone slave. Define INT_CTRL_SYNC_EN to add a 2-flop input synchroniser.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned       N_SRC        = 6,
    parameter logic [BUS_W-1:0]  MASK_RESET   = 32'hFFFF_FFFF,
    parameter logic [BUS_W-1:0]  NO_IRQ_CAUSE = NO_IRQ_CAUSE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    int_ctrl_if.slave         bus,
    input  logic [N_SRC-1:0]  irq_src,
    output logic              INT,
    output logic [BUS_W-1:0]  CAUSE
);

    bus_state_e        state_q;
    bus_state_e        state_d;
    logic              access_c;
    logic              ack_d;
    logic              ack_q;
    logic [BUS_W-1:0]  dat_q;

    logic [N_SRC-1:0]  src_s;
    logic [N_SRC-1:0]  prev_q;
    logic [N_SRC-1:0]  pending_q;
    logic [N_SRC-1:0]  mask_q;
    logic [N_SRC-1:0]  rise_c;
    logic [N_SRC-1:0]  active_c;
    logic [N_SRC-1:0]  clr_c;
    logic [N_SRC-1:0]  claim_bit_c;
    logic              mask_we_c;
    logic [BUS_W-1:0]  rdata_c;

    logic              enc_valid;
    logic [IDX_W-1:0]  enc_index;
    logic              int_q;
    logic [BUS_W-1:0]  cause_q;

    logic              unused_ok;

`ifdef INT_CTRL_SYNC_EN
    logic [N_SRC-1:0] sync1_q;
    logic [N_SRC-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = irq_src;
`endif

    // Bus FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            BUS_IDLE: if (bus.STB)  state_d = BUS_WAIT;
            BUS_WAIT: if (!bus.STB) state_d = BUS_IDLE;
            default:                state_d = BUS_IDLE;
        endcase
    end

    // Bus FSM: outputs; the access fires only on the IDLE->WAIT step
    always_comb begin
        access_c = 1'b0;
        ack_d    = ack_q;
        case (state_q)
            BUS_IDLE: begin
                if (bus.STB) begin
                    access_c = 1'b1;
                    ack_d    = 1'b1;
                end
            end
            BUS_WAIT: if (!bus.STB) ack_d = 1'b0;
            default:  ack_d = 1'b0;
        endcase
    end

    assign rise_c      = src_s & ~prev_q;
    assign active_c    = pending_q & mask_q;
    assign claim_bit_c = N_SRC'(1) << cause_q[IDX_W-1:0];

    // Register decode: read data plus write/claim side effects
    always_comb begin
        rdata_c   = '0;
        clr_c     = '0;
        mask_we_c = 1'b0;
        case (bus.ADDR[3:2])
            REG_PENDING: begin
                rdata_c = BUS_W'(pending_q);
                if (bus.WE) clr_c = bus.DAT_I[N_SRC-1:0];
            end
            REG_MASK: begin
                rdata_c   = BUS_W'(mask_q);
                mask_we_c = bus.WE;
            end
            REG_CAUSE: rdata_c = cause_q;
            REG_CLAIM: begin
                rdata_c = cause_q;
                if (!bus.WE && (cause_q != NO_IRQ_CAUSE)) clr_c = claim_bit_c;
            end
        endcase
        if (!access_c) begin
            clr_c     = '0;
            mask_we_c = 1'b0;
        end
    end

    int_prio_enc #(.N_SRC(N_SRC)) u_prio (
        .vec   (active_c),
        .valid (enc_valid),
        .index (enc_index)
    );

    // Pending/mask state and registered bus and CPU outputs; a new edge wins over a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= MASK_RESET[N_SRC-1:0];
            int_q     <= 1'b0;
            cause_q   <= NO_IRQ_CAUSE;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            prev_q    <= src_s;
            pending_q <= (pending_q & ~clr_c) | rise_c;
            if (mask_we_c) mask_q <= bus.DAT_I[N_SRC-1:0];
            int_q     <= enc_valid;
            cause_q   <= enc_valid ? BUS_W'(enc_index) : NO_IRQ_CAUSE;
            ack_q     <= ack_d;
            if (access_c) dat_q <= rdata_c;
        end
    end

    assign bus.ACK   = ack_q;
    assign bus.DAT_O = dat_q;
    assign INT       = int_q;
    assign CAUSE     = cause_q;

    assign unused_ok = ^{bus.ADDR[BUS_W-1:4], bus.ADDR[1:0], bus.DAT_I};

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios followed by a random
// phase, all compared every cycle against a behavioural model.
module tb_int_ctrl;

    localparam int unsigned N      = 6;
    localparam logic [31:0] NO_IRQ = 32'hFFFF_FFFF;
`ifdef INT_CTRL_SYNC_EN
    localparam int unsigned LAT_INT = 4;
    localparam int unsigned SYNC_D  = 2;
`else
    localparam int unsigned LAT_INT = 2;
    localparam int unsigned SYNC_D  = 0;
`endif

    logic          clk;
    logic          rst;
    logic [N-1:0]  irq_src;
    logic          intr;
    logic [31:0]   cause;

    int n_checks;
    int n_errors;

    int_ctrl_if bus_if ();

    int_ctrl #(.N_SRC(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .irq_src (irq_src),
        .INT     (intr),
        .CAUSE   (cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [N-1:0] m_pending, m_mask, m_prev, m_s1, m_s2;
    logic         m_busy, m_int;
    logic [31:0]  m_dat, m_cause;

    function automatic logic [31:0] lowest(input logic [N-1:0] v);
        for (int i = 0; i < int'(N); i++) if (v[i]) return 32'(i);
        return NO_IRQ;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock, updating the model from the inputs seen at that edge
    task automatic tick();
        logic [N-1:0] src_s, rise, act, np, nm, src_now;
        logic [31:0]  nd;
        logic         nb, r;
        int           ci;
        r       = rst;
        src_now = irq_src;
        src_s   = (SYNC_D != 0) ? m_s2 : irq_src;
        rise    = src_s & ~m_prev;
        act     = m_pending & m_mask;
        np = m_pending; nm = m_mask; nd = m_dat; nb = m_busy;
        if (bus_if.STB && !m_busy) begin
            nb = 1'b1;
            case (bus_if.ADDR[3:2])
                2'd0: begin
                    nd = 32'(m_pending);
                    if (bus_if.WE) np = np & ~bus_if.DAT_I[N-1:0];
                end
                2'd1: begin
                    nd = 32'(m_mask);
                    if (bus_if.WE) nm = bus_if.DAT_I[N-1:0];
                end
                2'd2: nd = m_cause;
                default: begin
                    nd = m_cause;
                    if (!bus_if.WE && m_cause != NO_IRQ) begin
                        ci = int'(m_cause);
                        np[ci] = 1'b0;
                    end
                end
            endcase
        end else if (!bus_if.STB) begin
            nb = 1'b0;
        end
        np = np | rise;
        @(posedge clk);
        #1;
        if (r) begin
            m_pending = '0; m_mask = '1; m_prev = '0; m_s1 = '0; m_s2 = '0;
            m_busy = 1'b0; m_dat = '0; m_int = 1'b0; m_cause = NO_IRQ;
        end else begin
            m_s2 = m_s1; m_s1 = src_now; m_prev = src_s;
            m_pending = np; m_mask = nm; m_busy = nb; m_dat = nd;
            m_int = (act != '0); m_cause = lowest(act);
        end
    endtask

    task automatic step();
        tick();
        check("ack", 32'(bus_if.ACK), 32'(m_busy));
        check("dat_o", bus_if.DAT_O, m_dat);
        check("int", 32'(intr), 32'(m_int));
        check("cause", cause, m_cause);
    endtask

    task automatic bus_op(input logic we, input logic [1:0] sel, input logic [31:0] wdata,
                          input int hold, output logic [31:0] rdata);
        int n;
        n = 0;
        bus_if.STB = 1'b1; bus_if.WE = we;
        bus_if.ADDR = {28'd0, sel, 2'b00}; bus_if.DAT_I = wdata;
        step();
        while (!bus_if.ACK && n < 8) begin step(); n++; end
        check("ack_rise", 32'(bus_if.ACK), 32'd1);
        for (int i = 1; i < hold; i++) begin
            step();
            check("ack_hold", 32'(bus_if.ACK), 32'd1);
        end
        rdata = bus_if.DAT_O;
        bus_if.STB = 1'b0; bus_if.WE = 1'b0;
        step();
        check("ack_fall", 32'(bus_if.ACK), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; irq_src = '0; bus_if.STB = 1'b0; bus_if.WE = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        int          hold_cnt;
        n_checks = 0; n_errors = 0; hold_cnt = 0;
        rst = 1'b1; irq_src = '0;
        bus_if.STB = 1'b0; bus_if.WE = 1'b0; bus_if.ADDR = '0; bus_if.DAT_I = '0;
        m_pending = '0; m_mask = '1; m_prev = '0; m_s1 = '0; m_s2 = '0;
        m_busy = 1'b0; m_dat = '0; m_int = 1'b0; m_cause = NO_IRQ;

        // Reset state
        do_reset();
        check("rst_int", 32'(intr), 32'd0);
        check("rst_cause", cause, NO_IRQ);
        check("rst_ack", 32'(bus_if.ACK), 32'd0);
        check("rst_dat", bus_if.DAT_O, 32'd0);
        bus_op(1'b0, 2'd1, 32'd0, 1, rd);
        check("rst_mask", rd, 32'h3F);

        // Single source edge and its latency to INT/CAUSE
        irq_src[3] = 1'b1;
        for (int i = 0; i < int'(LAT_INT) - 1; i++) begin
            step();
            check("lat_int_low", 32'(intr), 32'd0);
        end
        step();
        check("lat_int_high", 32'(intr), 32'd1);
        check("lat_cause", cause, 32'h3);
        bus_op(1'b0, 2'd0, 32'd0, 1, rd);
        check("pend_bit3", rd, 32'h8);

        // Two sources, claim in priority order
        do_reset();
        irq_src = 6'b10_0010;
        repeat (LAT_INT) step();
        check("two_cause", cause, 32'h1);
        bus_op(1'b0, 2'd3, 32'd0, 1, rd);
        check("claim1", rd, 32'h1);
        check("claim1_cause", cause, 32'h5);
        bus_op(1'b0, 2'd0, 32'd0, 1, rd);
        check("claim1_pend", rd, 32'h20);
        bus_op(1'b0, 2'd3, 32'd0, 1, rd);
        check("claim2", rd, 32'h5);
        check("claim2_int", 32'(intr), 32'd0);
        check("claim2_cause", cause, NO_IRQ);

        // Masking hides but keeps pending
        do_reset();
        irq_src = 6'b00_0100;
        repeat (LAT_INT) step();
        bus_op(1'b1, 2'd1, 32'h0, 1, rd);
        check("mask0_int", 32'(intr), 32'd0);
        bus_op(1'b0, 2'd0, 32'd0, 1, rd);
        check("mask0_pend", rd, 32'h4);
        bus_op(1'b1, 2'd1, 32'h4, 1, rd);
        check("mask4_int", 32'(intr), 32'd1);
        check("mask4_cause", cause, 32'h2);

        // Long strobe on a claim clears exactly one bit
        do_reset();
        irq_src = 6'b01_0010;
        repeat (LAT_INT) step();
        bus_op(1'b0, 2'd3, 32'd0, 10, rd);
        check("long_claim", rd, 32'h1);
        bus_op(1'b0, 2'd0, 32'd0, 1, rd);
        check("long_pend", rd, 32'h10);

        // W1C colliding with a new edge on the same bit: set wins
        do_reset();
        irq_src[0] = 1'b1;
        step();
        irq_src[0] = 1'b0;
        repeat (LAT_INT + 1) step();
        irq_src[0] = 1'b1;
        repeat (SYNC_D) step();
        bus_op(1'b1, 2'd0, 32'h1, 1, rd);
        bus_op(1'b0, 2'd0, 32'd0, 1, rd);
        check("w1c_collide", rd, 32'h1);
        bus_op(1'b1, 2'd0, 32'h1, 1, rd);
        bus_op(1'b0, 2'd0, 32'd0, 1, rd);
        check("w1c_plain", rd, 32'h0);

        // Reset arriving mid-transaction
        do_reset();
        irq_src[2] = 1'b1;
        repeat (LAT_INT) step();
        bus_if.STB = 1'b1; bus_if.WE = 1'b0; bus_if.ADDR = 32'h4;
        step();
        check("wait_ack", 32'(bus_if.ACK), 32'd1);
        rst = 1'b1; irq_src = '0;
        step();
        check("rstw_ack", 32'(bus_if.ACK), 32'd0);
        check("rstw_cause", cause, NO_IRQ);
        rst = 1'b0; bus_if.STB = 1'b0;
        step();
        check("rstw_idle", 32'(bus_if.ACK), 32'd0);
        bus_op(1'b0, 2'd0, 32'd0, 1, rd);
        check("rstw_pend", rd, 32'h0);
        bus_op(1'b0, 2'd1, 32'd0, 2, rd);
        check("rstw_mask", rd, 32'h3F);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) irq_src = N'($urandom);
            if (!bus_if.STB && !bus_if.ACK && $urandom_range(0, 2) == 0) begin
                bus_if.STB   = 1'b1;
                bus_if.WE    = 1'($urandom);
                bus_if.ADDR  = $urandom;
                bus_if.DAT_I = $urandom;
                hold_cnt     = int'($urandom_range(0, 3));
            end else if (bus_if.STB && bus_if.ACK) begin
                if (hold_cnt == 0) bus_if.STB = 1'b0;
                else hold_cnt--;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
